// File: rtl/soft_rst_pkg.sv
// Shared types and default timing for the soft-reset sequencer.
package soft_rst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    ASSERT  = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_SW    = 2'b01,
    CAUSE_WDT   = 2'b10,
    CAUSE_SW_TO = 2'b11
  } cause_e;

  localparam int unsigned HOLD_CYCLES_DEF    = 16;
  localparam int unsigned RELEASE_CYCLES_DEF = 4;
  localparam int unsigned DRAIN_TIMEOUT_DEF  = 1024;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soft_rst_ctrl.sv
// Soft-reset sequencer: drain bus traffic, hold rst_soft_o low, wait out the
// release synchroniser, then pulse done_o. Lives in the always-on domain.
module soft_rst_ctrl
  import soft_rst_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF,
  parameter int unsigned DRAIN_TIMEOUT  = DRAIN_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sw_req_i,
  input  logic       wdt_req_i,
  input  logic       bus_idle_i,
  output logic       halt_req_o,
  output logic       rst_soft_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] cause_o
);

  localparam int unsigned CNT_W =
    $clog2(max3(HOLD_CYCLES, RELEASE_CYCLES, DRAIN_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(RELEASE_CYCLES - 1);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic             rst_soft_q, rst_soft_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (wdt_req_i) begin
          state_d = ASSERT;
          cause_d = CAUSE_WDT;
        end else if (sw_req_i) begin
          state_d = DRAIN;
          cause_d = CAUSE_SW;
        end
      end
      DRAIN: begin
        // Watchdog overrides both the idle handshake and the timeout.
        if (wdt_req_i) begin
          state_d = ASSERT;
          cause_d = CAUSE_WDT;
        end else if (bus_idle_i) begin
          state_d = ASSERT;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ASSERT;
          cause_d = CAUSE_SW_TO;
        end
      end
      ASSERT:  if (cnt_q == HOLD_LAST) state_d = RELEASE;
      RELEASE: if (cnt_q == REL_LAST)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;

    // Outputs decode the next state so every output leaves a flop directly.
    busy_d     = (state_d inside {DRAIN, ASSERT, RELEASE});
    halt_d     = (state_d inside {DRAIN, ASSERT, RELEASE});
    rst_soft_d = (state_d != ASSERT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cause_q    <= CAUSE_NONE;
      cnt_q      <= '0;
      halt_q     <= 1'b0;
      rst_soft_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      halt_q     <= halt_d;
      rst_soft_q <= rst_soft_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign halt_req_o = halt_q;
  assign rst_soft_o = rst_soft_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cause_o    = cause_q;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
// Directed bench for soft_rst_ctrl: a default instance and a short-timeout instance.
module tb_soft_rst_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sw_req = 1'b0;
  logic wdt_req = 1'b0;
  logic bus_idle = 1'b1;

  logic       halt_a, rsts_a, busy_a, done_a;
  logic [1:0] cause_a;
  logic       halt_b, rsts_b, busy_b, done_b;
  logic [1:0] cause_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soft_rst_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_req_i(sw_req), .wdt_req_i(wdt_req),
    .bus_idle_i(bus_idle), .halt_req_o(halt_a), .rst_soft_o(rsts_a),
    .busy_o(busy_a), .done_o(done_a), .cause_o(cause_a)
  );

  soft_rst_ctrl #(.DRAIN_TIMEOUT(8)) dut_to (
    .clk_i(clk), .rst_ni(rst_n), .sw_req_i(sw_req), .wdt_req_i(wdt_req),
    .bus_idle_i(bus_idle), .halt_req_o(halt_b), .rst_soft_o(rsts_b),
    .busy_o(busy_b), .done_o(done_b), .cause_o(cause_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sw();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
  endtask

  // Walks one sequence from the current cycle until the done pulse (bounded).
  task automatic measure(input bit sel, output int dr, output int lo, output int rl,
                         output int dn, output int hb);
    bit seen_low;
    logic h, r, b, d;
    seen_low = 1'b0;
    dr = 0; lo = 0; rl = 0; dn = 0; hb = 0;
    for (int i = 0; i < 2000; i++) begin
      h = sel ? halt_b : halt_a;
      r = sel ? rsts_b : rsts_a;
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      if (d) begin
        dn++;
        if (h || b) hb++;
        break;
      end
      if (!r) begin
        lo++;
        seen_low = 1'b1;
      end else if (b) begin
        if (seen_low) rl++;
        else dr++;
      end
      if (b && !h) hb++;
      if (!r && !b) hb++;
      tick();
    end
  endtask

  int dr, lo, rl, dn, hb, bad;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_soft_reset", rsts_a, 1);
    chk("busy_reset", busy_a, 0);
    chk("halt_reset", halt_a, 0);
    chk("done_reset", done_a, 0);
    chk("cause_reset", cause_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", busy_a, 0);

    // Basic software request with an idle bus
    bus_idle = 1'b1;
    pulse_sw();
    chk("sw_drain_busy", busy_a, 1);
    chk("sw_drain_halt", halt_a, 1);
    chk("sw_drain_rst", rsts_a, 1);
    measure(1'b0, dr, lo, rl, dn, hb);
    chk("sw_drain_cycles", dr, 1);
    chk("sw_low_cycles", lo, 16);
    chk("sw_release_cycles", rl, 4);
    chk("sw_done_pulse", dn, 1);
    chk("sw_halt_track", hb, 0);
    chk("sw_cause", cause_a, 1);
    tick();
    chk("sw_done_one_cycle", done_a, 0);
    chk("sw_idle_busy", busy_a, 0);
    chk("sw_cause_sticky", cause_a, 1);

    // Drain wait: bus busy for 50 cycles
    bus_idle = 1'b0;
    pulse_sw();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!halt_a || !rsts_a || !busy_a) bad++;
      tick();
    end
    chk("wait_halt_no_rst", bad, 0);
    bus_idle = 1'b1;
    measure(1'b0, dr, lo, rl, dn, hb);
    chk("wait_drain_cycles", dr, 1);
    chk("wait_low_cycles", lo, 16);
    chk("wait_done", dn, 1);
    chk("wait_cause", cause_a, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("wait_to_inst_idle", busy_b, 0);
    chk("wait_to_inst_cause", cause_b, 3);

    // Drain timeout on the short-timeout instance
    bus_idle = 1'b0;
    pulse_sw();
    measure(1'b1, dr, lo, rl, dn, hb);
    chk("to_drain_cycles", dr, 8);
    chk("to_low_cycles", lo, 16);
    chk("to_release_cycles", rl, 4);
    chk("to_done", dn, 1);
    chk("to_halt_track", hb, 0);
    chk("to_cause", cause_b, 3);
    chk("to_default_still_drain", busy_a, 1);
    bus_idle = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("to_default_finished", busy_a, 0);

    // Simultaneous SW and WDT: watchdog wins, no drain
    sw_req = 1'b1;
    wdt_req = 1'b1;
    tick();
    sw_req = 1'b0;
    wdt_req = 1'b0;
    measure(1'b0, dr, lo, rl, dn, hb);
    chk("wdt_drain_cycles", dr, 0);
    chk("wdt_low_cycles", lo, 16);
    chk("wdt_release_cycles", rl, 4);
    chk("wdt_cause", cause_a, 2);
    tick();

    // Watchdog mid-drain
    bus_idle = 1'b0;
    pulse_sw();
    tick(); tick(); tick();
    chk("mid_still_drain", rsts_a, 1);
    wdt_req = 1'b1;
    tick();
    wdt_req = 1'b0;
    chk("mid_wdt_assert", rsts_a, 0);
    chk("mid_wdt_assert_to", rsts_b, 0);
    chk("mid_wdt_cause", cause_a, 2);
    bus_idle = 1'b1;
    measure(1'b0, dr, lo, rl, dn, hb);
    chk("mid_low_cycles", lo, 16);
    chk("mid_done", dn, 1);
    tick();

    // Request during ASSERT is ignored
    pulse_sw();
    tick();
    pulse_sw();
    measure(1'b0, dr, lo, rl, dn, hb);
    chk("ign_low_cycles", lo, 15);
    chk("ign_done", dn, 1);
    tick();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a || done_a) bad++;
      tick();
    end
    chk("ign_no_second_seq", bad, 0);

    // Asynchronous reset at the fifth ASSERT cycle
    pulse_sw();
    tick();
    tick(); tick(); tick(); tick();
    chk("ar_in_assert", rsts_a, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rst_soft", rsts_a, 1);
    chk("ar_busy", busy_a, 0);
    chk("ar_halt", halt_a, 0);
    chk("ar_cause", cause_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_a || busy_a || !rsts_a) bad++;
      tick();
    end
    chk("ar_no_done", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soft_rst_ctrl.md
Name: soft_rst_ctrl

Overview:
- Generates the active-low soft-reset request `rst_soft_o`, which feeds the core clock/reset generator's soft-reset input.
- That generator ANDs it with `rst_ni` and synchronises the result.
- Accepts a software request (CSR write pulse) and a watchdog expiry, drains outstanding bus traffic, then holds soft reset for a programmed time.
- Waits out the release synchroniser, then reports completion. The block itself is clocked and reset only by the always-on `clk_i`/`rst_ni` domain and is never reset by its own output.

Parameters:
- HOLD_CYCLES, 16, cycles `rst_soft_o` is held low (≥2).
- RELEASE_CYCLES, 4, cycles waited after deassertion before done (≥ synchroniser depth 2 + margin).
- DRAIN_TIMEOUT, 1024, maximum cycles waiting for bus idle before forcing reset (≥1).
- CNT_W, $clog2(max(HOLD_CYCLES,RELEASE_CYCLES,DRAIN_TIMEOUT)+1), counter width; derived, not overridden.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset, always-on domain; one clock, reset asynchronous and active-low
- sw_req_i  in  1  single-cycle software soft-reset request
- wdt_req_i  in  1  watchdog expiry request, level or pulse
- bus_idle_i  in  1  high when no outstanding bus transactions
- halt_req_o  out  1  asks core/bus masters to stop issuing new requests
- rst_soft_o  out  1  active-low soft reset to the clock/reset generator
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when the sequence completes
- cause_o  out  2  last cause: 00 none, 01 SW, 10 WDT, 11 SW+drain timeout

Behaviour:
- Reset values (`rst_ni`=0, asynchronous): state IDLE, counter 0, `halt_req_o`=0, `rst_soft_o`=1, `busy_o`=0, `done_o`=0, `cause_o`=00. All outputs are registered.
- FSM states: IDLE, DRAIN, ASSERT, RELEASE, DONE. Encoding comes from the package.
- IDLE:
  - `wdt_req_i`=1 -> ASSERT, `cause_o`<=10, no drain.
  - Else `sw_req_i`=1 -> DRAIN, `cause_o`<=01.
  - Counter is cleared on either transition.
- DRAIN:
  - `halt_req_o`=1 and `busy_o`=1.
  - `bus_idle_i`=1 -> ASSERT (the same cycle's idle counts).
  - Counter reaches DRAIN_TIMEOUT-1 without idle -> ASSERT, `cause_o`<=11.
  - `wdt_req_i`=1 -> ASSERT immediately, `cause_o`<=10. WDT has priority over idle and timeout.
- ASSERT:
  - `rst_soft_o`=0, `halt_req_o`=1.
  - Held exactly HOLD_CYCLES cycles: first low cycle is the cycle after entry, last is when counter = HOLD_CYCLES-1.
  - Then -> RELEASE.
- RELEASE:
  - `rst_soft_o`=1, `halt_req_o`=1.
  - Lasts RELEASE_CYCLES cycles, then -> DONE.
- DONE:
  - `done_o`=1 for exactly one cycle, `halt_req_o`=0, `busy_o`=0 -> IDLE.
- Request handling:
  - Requests arriving in any non-IDLE state are ignored and not queued.
  - Exception: `wdt_req_i` in DRAIN, as above.
  - A `wdt_req_i` level still high on return to IDLE restarts the sequence. This is intended.
  - Simultaneous `sw_req_i` and `wdt_req_i` in IDLE: WDT wins, `cause_o`=10.
- `cause_o` is sticky until the next accepted request and is not cleared by the soft reset itself.
- `busy_o`=1 in DRAIN, ASSERT and RELEASE. It is 0 in IDLE and DONE.
- Counter: a single CNT_W counter, cleared on every state transition. It never wraps because each state exits at its terminal count.
- `rst_ni` asserted mid-sequence: immediate return to reset values, including `rst_soft_o`=1. The hard reset dominates downstream anyway.
- Glitch-free `rst_soft_o`: it must come straight from a flop, with no combinational decode on the output path.

Decomposition:
- Package soft_rst_pkg holds:
  - `state_e` enum (IDLE, DRAIN, ASSERT, RELEASE, DONE).
  - `cause_e` 2-bit enum (CAUSE_NONE, CAUSE_SW, CAUSE_WDT, CAUSE_SW_TO).
  - Default timing constants.
- No sub-module: the single FSM plus one counter stays within about 150 lines.
- Instantiate next to the clock/reset generator in corecomplex, with `rst_soft_o` driving its soft-reset input.

Test Plan:
- Basic SW request: `rst_ni` released, `bus_idle_i`=1, pulse `sw_req_i` at cycle 10 -> DRAIN at cycle 11, `rst_soft_o` low cycles 12–27 (16 cycles), RELEASE 28–31, `done_o` pulse at 32, `cause_o`=01.
- Drain wait: `bus_idle_i`=0 for 50 cycles after the request -> `halt_req_o` high throughout, `rst_soft_o` stays 1 until idle, then 16 low cycles; `cause_o`=01.
- Drain timeout: DRAIN_TIMEOUT=8, `bus_idle_i` stuck at 0 -> ASSERT after 8 DRAIN cycles, `cause_o`=11, full sequence completes.
- WDT priority: `sw_req_i` and `wdt_req_i` asserted in the same cycle -> no DRAIN, direct ASSERT, `cause_o`=10. Separately, `wdt_req_i` in mid-DRAIN -> ASSERT on the next cycle.
- Ignored request: `sw_req_i` pulsed during ASSERT -> exactly one `done_o` pulse, no second sequence.
- Async reset mid-ASSERT: drop `rst_ni` at cycle 5 of ASSERT -> `rst_soft_o`=1, `busy_o`=0, `cause_o`=00 immediately, without waiting for a clock edge; `done_o` never pulses.
